// File: rtl/regfile_scoreboard.sv
// 8x8 register file with per-register in-flight write counters for RAW stall generation.
// Optional same-cycle commit bypass on both read ports: define REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 2,
  parameter int R0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_final,
  input  logic [ADDR_W-1:0] rd_final,
  input  logic [DATA_W-1:0] write_data_WB,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              rs1_used,
  input  logic              rs2_used,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              kill_valid,
  input  logic [ADDR_W-1:0] kill_rd,
  output logic              stall,
  output logic              sb_err
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0]       r_regs [NREGS];
  logic [CNT_W-1:0]        r_cnt  [NREGS];
  logic                    r_sb_err;

  logic                    w_wr_en;
  logic                    w_issue_en;
  logic [DATA_W-1:0]       w_rs1_data;
  logic [DATA_W-1:0]       w_rs2_data;
  logic                    w_haz1;
  logic                    w_haz2;
  logic                    w_inc   [NREGS];
  logic                    w_dec_c [NREGS];
  logic                    w_dec_k [NREGS];
  logic signed [CNT_W+1:0] w_sum   [NREGS];
  logic [CNT_W-1:0]        w_cnt_nxt [NREGS];
  logic                    w_err_any;

  assign w_wr_en    = RegWrite_final && !(R0_ZERO != 0 && rd_final == '0);
  assign w_issue_en = issue_valid && !stall && issue_regwrite;

  always_comb begin
    w_rs1_data = r_regs[rs1_addr];
    w_rs2_data = r_regs[rs2_addr];
    w_haz1     = rs1_used && (r_cnt[rs1_addr] != '0);
    w_haz2     = rs2_used && (r_cnt[rs2_addr] != '0);
`ifdef REGFILE_BYPASS_EN
    // The committing value is the last one outstanding, so forward it and drop the hazard.
    if (w_wr_en && rd_final == rs1_addr) begin
      w_rs1_data = write_data_WB;
      if (r_cnt[rs1_addr] == CNT_W'(1)) w_haz1 = 1'b0;
    end
    if (w_wr_en && rd_final == rs2_addr) begin
      w_rs2_data = write_data_WB;
      if (r_cnt[rs2_addr] == CNT_W'(1)) w_haz2 = 1'b0;
    end
`endif
    if (R0_ZERO != 0 && rs1_addr == '0) begin
      w_rs1_data = '0;
      w_haz1     = 1'b0;
    end
    if (R0_ZERO != 0 && rs2_addr == '0) begin
      w_rs2_data = '0;
      w_haz2     = 1'b0;
    end
  end

  // Net increment and decrements in a 2-bit-wider signed sum so both
  // overflow (sum above max) and underflow (sum negative) are detectable.
  always_comb begin
    w_err_any = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      w_inc[i]     = w_issue_en && (issue_rd == ADDR_W'(i));
      w_dec_c[i]   = RegWrite_final && (rd_final == ADDR_W'(i));
      w_dec_k[i]   = kill_valid && (kill_rd == ADDR_W'(i));
      w_sum[i]     = $signed({2'b00, r_cnt[i]})
                   + $signed({{(CNT_W+1){1'b0}}, w_inc[i]})
                   - $signed({{(CNT_W+1){1'b0}}, w_dec_c[i]})
                   - $signed({{(CNT_W+1){1'b0}}, w_dec_k[i]});
      w_cnt_nxt[i] = w_sum[i][CNT_W-1:0];
      if (R0_ZERO != 0 && i == 0) begin
        w_cnt_nxt[i] = '0;
      end else if (w_sum[i][CNT_W+1]) begin
        w_cnt_nxt[i] = '0;
        w_err_any    = 1'b1;
      end else if (w_sum[i][CNT_W]) begin
        w_cnt_nxt[i] = '1;
        w_err_any    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_sb_err <= 1'b0;
    end else begin
      if (w_wr_en) r_regs[rd_final] <= write_data_WB;
      for (int i = 0; i < NREGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      if (w_err_any) r_sb_err <= 1'b1;
    end
  end

  assign rs1_data = w_rs1_data;
  assign rs2_data = w_rs2_data;
  assign stall    = w_haz1 || w_haz2;
  assign sb_err   = r_sb_err;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       RegWrite_final;
  logic [2:0] rd_final;
  logic [7:0] write_data_WB;
  logic [2:0] rs1_addr, rs2_addr;
  logic       rs1_used, rs2_used;
  logic [7:0] rs1_data, rs2_data;
  logic       issue_valid, issue_regwrite;
  logic [2:0] issue_rd;
  logic       kill_valid;
  logic [2:0] kill_rd;
  logic       stall;
  logic       sb_err;

  int n_vec = 0;
  int n_err = 0;

  regfile_scoreboard dut (
    .clk(clk), .reset(reset),
    .RegWrite_final(RegWrite_final), .rd_final(rd_final), .write_data_WB(write_data_WB),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_rd(issue_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .stall(stall), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_final = 1'b0; rd_final = '0; write_data_WB = '0;
    rs1_used = 1'b0; rs2_used = 1'b0; rs1_addr = '0; rs2_addr = '0;
    issue_valid = 1'b0; issue_regwrite = 1'b0; issue_rd = '0;
    kill_valid = 1'b0; kill_rd = '0;
  endtask

  task automatic issue(input logic [2:0] rd);
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = rd;
    tick();
    issue_valid = 1'b0; issue_regwrite = 1'b0;
  endtask

  task automatic commit(input logic [2:0] rd, input logic [7:0] d);
    RegWrite_final = 1'b1; rd_final = rd; write_data_WB = d;
    tick();
    RegWrite_final = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;

    // reset state of all registers
    for (int i = 0; i < 8; i++) begin
      rs1_addr = 3'(i); rs2_addr = 3'(7 - i); rs1_used = 1'b1; rs2_used = 1'b1;
      #1;
      check($sformatf("rst_rs1_r%0d", i), rs1_data, 8'h00);
      check($sformatf("rst_rs2_r%0d", 7 - i), rs2_data, 8'h00);
      check($sformatf("rst_stall_%0d", i), stall, 1'b0);
    end
    check("rst_sb_err", sb_err, 1'b0);
    idle();

    // commit 0xA7 to r5 (with matching issue first)
    issue(3'd5);
    rs1_addr = 3'd5;
    RegWrite_final = 1'b1; rd_final = 3'd5; write_data_WB = 8'hA7;
    #1;
    check("r5_commit_cycle", rs1_data, BYP ? 8'hA7 : 8'h00);
    tick();
    RegWrite_final = 1'b0;
    #1;
    check("r5_after", rs1_data, 8'hA7);

    // r0 ignores writes and never goes busy
    issue(3'd0);
    commit(3'd0, 8'hFF);
    rs1_addr = 3'd0; rs1_used = 1'b1;
    #1;
    check("r0_zero", rs1_data, 8'h00);
    check("r0_nostall", stall, 1'b0);
    idle();

    // RAW on r3; a gated issue to r7 during stall must not count
    issue(3'd3);
    rs2_addr = 3'd3; rs2_used = 1'b1;
    #1;
    check("r3_stall_a", stall, 1'b1);
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 3'd7;
    tick();
    issue_valid = 1'b0; issue_regwrite = 1'b0;
    check("r3_stall_b", stall, 1'b1);
    RegWrite_final = 1'b1; rd_final = 3'd3; write_data_WB = 8'h3C;
    #1;
    check("r3_commit_stall", stall, BYP ? 1'b0 : 1'b1);
    check("r3_commit_data", rs2_data, BYP ? 8'h3C : 8'h00);
    tick();
    RegWrite_final = 1'b0;
    rs1_addr = 3'd7; rs1_used = 1'b1;
    #1;
    check("r3_post_stall", stall, 1'b0);
    check("r3_post_data", rs2_data, 8'h3C);
    idle();

    // issue + commit on r2 with cnt=1 nets to no change
    issue(3'd2);
    issue_valid = 1'b1; issue_regwrite = 1'b1; issue_rd = 3'd2;
    RegWrite_final = 1'b1; rd_final = 3'd2; write_data_WB = 8'h11;
    #1;
    check("r2_pre_stall", stall, 1'b0);
    tick();
    idle();
    rs1_addr = 3'd2; rs1_used = 1'b1;
    #1;
    check("r2_net_stall", stall, 1'b1);
    check("r2_net_data", rs1_data, 8'h11);
    RegWrite_final = 1'b1; rd_final = 3'd2; write_data_WB = 8'h22;
    #1;
    check("r2_commit_stall", stall, BYP ? 1'b0 : 1'b1);
    tick();
    RegWrite_final = 1'b0;
    #1;
    check("r2_done_stall", stall, 1'b0);
    check("r2_done_data", rs1_data, 8'h22);
    idle();

    // r4: two issues, one kill, one commit -> idle; extra kill -> underflow
    issue(3'd4);
    issue(3'd4);
    kill_valid = 1'b1; kill_rd = 3'd4;
    tick();
    kill_valid = 1'b0;
    rs1_addr = 3'd4; rs1_used = 1'b1;
    #1;
    check("r4_one_left", stall, 1'b1);
    rs1_used = 1'b0;
    commit(3'd4, 8'h44);
    rs1_used = 1'b1;
    #1;
    check("r4_stall", stall, 1'b0);
    check("r4_sb_err_clean", sb_err, 1'b0);
    kill_valid = 1'b1; kill_rd = 3'd4;
    tick();
    kill_valid = 1'b0;
    check("r4_underflow", sb_err, 1'b1);
    check("r4_underflow_stall", stall, 1'b0);
    tick(); tick(); tick();
    check("r4_sticky", sb_err, 1'b1);
    idle();

    // reset with cnt[r6]=2 and a commit pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_clears_err", sb_err, 1'b0);
    issue(3'd6);
    commit(3'd6, 8'h5A);
    issue(3'd6);
    issue(3'd6);
    rs1_addr = 3'd6; rs1_used = 1'b1;
    #1;
    check("r6_busy", stall, 1'b1);
    check("r6_data", rs1_data, 8'h5A);
    reset = 1'b1;
    RegWrite_final = 1'b1; rd_final = 3'd6; write_data_WB = 8'h66;
    tick();
    reset = 1'b0;
    RegWrite_final = 1'b0;
    #1;
    check("r6_rst_data", rs1_data, 8'h00);
    check("r6_rst_stall", stall, 1'b0);
    check("r6_rst_err", sb_err, 1'b0);
    idle();

    // overflow on r1: fourth pending writer saturates and flags
    issue(3'd1);
    issue(3'd1);
    issue(3'd1);
    check("r1_three_ok", sb_err, 1'b0);
    issue(3'd1);
    check("r1_overflow", sb_err, 1'b1);
    rs2_addr = 3'd1; rs2_used = 1'b1;
    #1;
    check("r1_sat_stall", stall, 1'b1);
    idle();
    // saturated at 3: three commits drain it
    commit(3'd1, 8'h01);
    commit(3'd1, 8'h02);
    rs2_addr = 3'd1; rs2_used = 1'b1;
    #1;
    check("r1_two_drained", stall, 1'b1);
    rs2_used = 1'b0;
    commit(3'd1, 8'h03);
    rs2_used = 1'b1;
    #1;
    check("r1_drained", stall, 1'b0);
    check("r1_data", rs2_data, 8'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
